wishbone_slave2: RTL and testbench
==================================

WISHBONE_SLAVE2 -- requirements
Module: wishbone_slave2

Interface
REQ-001 Parameter: DATA_W, default 64, width of all data buses.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 we_i  in  1  Wishbone write enable (1 = write, 0 = read).
REQ-006 adr_i  in  1  register select (0 = DATA, 1 = COMMAND/STATUS).
REQ-007 strobe  in  1  Wishbone strobe/cycle-valid.
REQ-008 wb_data_i  in  DATA_W  Wishbone write data.
REQ-009 host_data_i  in  DATA_W  result data from host.
REQ-010 done_i  in  1  host result valid, one-cycle qualifier for host_data_i.
REQ-011 new_data  out  1  one-cycle pulse: new DATA word on host_data_o.
REQ-012 new_command  out  1  one-cycle pulse: new COMMAND word on host_data_o.
REQ-013 host_data_o  out  DATA_W  last word written by master (registered).
REQ-014 wb_data_o  out  DATA_W  Wishbone read data (registered).
REQ-015 ack_o  out  1  Wishbone acknowledge, one-cycle pulse.

Function
REQ-016 FSM states: IDLE, ACK, WAIT_RELEASE; reset state IDLE.
REQ-017 IDLE: strobe=1 sampled -> perform access (REQ-018..021) and go to ACK.
REQ-018 Write, adr_i=0: host_data_o <= wb_data_i; new_data=1 in the ACK cycle only.
REQ-019 Write, adr_i=1: host_data_o <= wb_data_i; new_command=1 in the ACK cycle only.
REQ-020 Read, adr_i=0: wb_data_o <= rd_data_reg; valid flag cleared.
REQ-021 Read, adr_i=1: wb_data_o <= {zeros, valid flag} (status, bit 0).
REQ-022 ACK: ack_o=1 for exactly one cycle; go to WAIT_RELEASE if strobe still 1, else IDLE.
REQ-023 WAIT_RELEASE: ack_o=0; return to IDLE when strobe=0. A held strobe produces exactly one access and one ack.
REQ-024 Latency: ack_o rises one cycle after strobe is first sampled high; wb_data_o is valid in that same ack cycle.
REQ-025 Capture: done_i=1 -> rd_data_reg <= host_data_i and valid flag set. This happens in any state.
REQ-026 done_i and a DATA read in the same cycle: the read returns the old rd_data_reg. The new capture wins, so the valid flag ends up set.
REQ-027 done_i while valid is already 1: overwrite rd_data_reg; no overflow flag.
REQ-028 new_data and new_command are never asserted together and never asserted on reads.
REQ-029 host_data_o and wb_data_o hold their values between accesses.

Reset
REQ-030 reset=1 forces, asynchronously: state=IDLE, ack_o=0, new_data=0, new_command=0, host_data_o=0, wb_data_o=0, rd_data_reg=0, valid=0.
REQ-031 Reset during ACK or WAIT_RELEASE aborts the access; no ack after release unless strobe is sampled high again in IDLE.

Structure
REQ-032 Shared package: state encoding (IDLE=0, ACK=1, WAIT_RELEASE=2), ADR_DATA=0, ADR_CMD=1, DATA_W default.
REQ-033 Single module; no sub-module required.
REQ-034 The companion stimulus generator is named wb_slave_stim and is bench-only, not synthesized.

Verification
REQ-035 Scenario 1: write adr=0, data 0x0123456789ABCDEF, strobe held 3 cycles -> one ack_o pulse 1 cycle after strobe; new_data pulse; host_data_o=0x0123456789ABCDEF.
REQ-036 Scenario 2: write adr=1, data 0xA5 -> new_command pulse only; host_data_o=0xA5; new_data stays 0.
REQ-037 Scenario 3: done_i pulse with host_data_i=0xDEADBEEF, then read adr=1 -> wb_data_o=1; read adr=0 -> wb_data_o=0xDEADBEEF; next read adr=1 -> 0.
REQ-038 Scenario 4: strobe held 10 cycles -> exactly one ack_o; after strobe low for 1 cycle and high again -> second ack.
REQ-039 Scenario 5: assert reset mid-ACK -> all outputs 0 immediately; no ack after reset release while strobe=0.
REQ-040 Scenario 6: done_i (0x55) in the same cycle as a DATA read with old data 0x11 -> read returns 0x11; subsequent status read returns 1.

Source files
------------

// File: rtl/wishbone_slave2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_slave2_pkg
//  Brief    : Shared FSM encoding, register addresses and width default for
//             the two-register Wishbone slave.
//  Revision : 1.0
// ============================================================================
package wishbone_slave2_pkg;

    localparam int DATA_W_DEF = 64;

    localparam logic ADR_DATA = 1'b0;
    localparam logic ADR_CMD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ACK          = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } wb_state_t;

endpackage : wishbone_slave2_pkg
`default_nettype wire

// File: rtl/wishbone_slave2.sv
`default_nettype none
// ============================================================================
//  Module   : wishbone_slave2
//  Brief    : Single-beat Wishbone slave with a DATA and a COMMAND/STATUS
//             register bridging a bus master to a host engine.
//  Revision : 1.0
// ============================================================================
module wishbone_slave2
    import wishbone_slave2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we_i,
    input  logic              adr_i,
    input  logic              strobe,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic [DATA_W-1:0] host_data_i,
    input  logic              done_i,
    output logic              new_data,
    output logic              new_command,
    output logic [DATA_W-1:0] host_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              ack_o
);

    wb_state_t         r_state;
    wb_state_t         w_next_state;
    logic              w_access;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_access     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (strobe) begin
                    w_access     = 1'b1;
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                w_next_state = strobe ? ST_WAIT_RELEASE : ST_IDLE;
            end
            ST_WAIT_RELEASE: begin
                if (!strobe) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Ack is a pure decode of the state register, so it is glitch-free and
    // drops the instant reset forces the state back to idle.
    assign ack_o = (r_state == ST_ACK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            host_data_o <= '0;
            wb_data_o   <= '0;
            new_data    <= 1'b0;
            new_command <= 1'b0;
        end else begin
            new_data    <= w_access && we_i && (adr_i == ADR_DATA);
            new_command <= w_access && we_i && (adr_i == ADR_CMD);
            if (w_access) begin
                if (we_i) begin
                    host_data_o <= wb_data_i;
                end else if (adr_i == ADR_DATA) begin
                    wb_data_o <= r_rd_data;
                end else begin
                    wb_data_o <= {{(DATA_W-1){1'b0}}, r_valid};
                end
            end
        end
    end

    // A host capture in the same cycle as a DATA read takes priority, so the
    // freshly captured word is never lost behind a cleared flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
            r_valid   <= 1'b0;
        end else if (done_i) begin
            r_rd_data <= host_data_i;
            r_valid   <= 1'b1;
        end else if (w_access && !we_i && (adr_i == ADR_DATA)) begin
            r_valid   <= 1'b0;
        end
    end

endmodule : wishbone_slave2
`default_nettype wire

// File: tb/tb_wishbone_slave2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wishbone_slave2
//  Brief    : Directed self-checking bench for wishbone_slave2.
//  Revision : 1.0
// ============================================================================
module tb_wishbone_slave2;

    localparam int DATA_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              we_i;
    logic              adr_i;
    logic              strobe;
    logic [DATA_W-1:0] wb_data_i;
    logic [DATA_W-1:0] host_data_i;
    logic              done_i;
    logic              new_data;
    logic              new_command;
    logic [DATA_W-1:0] host_data_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              ack_o;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_cnt  = 0;
    int nd_cnt   = 0;
    int nc_cnt   = 0;

    wishbone_slave2 #(.DATA_W(DATA_W)) u_dut (
        .clock       (clock),
        .reset       (reset),
        .we_i        (we_i),
        .adr_i       (adr_i),
        .strobe      (strobe),
        .wb_data_i   (wb_data_i),
        .host_data_i (host_data_i),
        .done_i      (done_i),
        .new_data    (new_data),
        .new_command (new_command),
        .host_data_o (host_data_o),
        .wb_data_o   (wb_data_o),
        .ack_o       (ack_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ack_o)       ack_cnt++;
        if (new_data)    nd_cnt++;
        if (new_command) nc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One bus access with strobe held for 'hold' cycles, then one idle cycle.
    task automatic wb_access(input logic we, input logic adr,
                             input logic [DATA_W-1:0] data, input int hold,
                             output logic [DATA_W-1:0] rdata);
        int a0;
        a0        = ack_cnt;
        we_i      = we;
        adr_i     = adr;
        wb_data_i = data;
        strobe    = 1'b1;
        step();
        check_eq("ack_latency", {63'd0, ack_o}, 64'd1);
        rdata = wb_data_o;
        for (int i = 1; i < hold; i++) step();
        strobe = 1'b0;
        we_i   = 1'b0;
        step();
        check_eq("ack_count", 64'(ack_cnt - a0), 64'd1);
    endtask

    task automatic host_done(input logic [DATA_W-1:0] data);
        host_data_i = data;
        done_i      = 1'b1;
        step();
        done_i      = 1'b0;
    endtask

    logic [DATA_W-1:0] rd;
    int a_snap, d_snap, c_snap;

    initial begin
        reset = 1'b1; we_i = 1'b0; adr_i = 1'b0; strobe = 1'b0;
        wb_data_i = '0; host_data_i = '0; done_i = 1'b0;
        step(); step();
        check_eq("rst_ack", {63'd0, ack_o}, 64'd0);
        check_eq("rst_host_data", host_data_o, 64'd0);
        check_eq("rst_wb_data", wb_data_o, 64'd0);
        reset = 1'b0;
        step();

        // Write DATA, strobe held 3 cycles
        d_snap = nd_cnt; c_snap = nc_cnt;
        wb_access(1'b1, 1'b0, 64'h0123456789ABCDEF, 3, rd);
        check_eq("s1_host_data", host_data_o, 64'h0123456789ABCDEF);
        check_eq("s1_new_data", 64'(nd_cnt - d_snap), 64'd1);
        check_eq("s1_new_cmd", 64'(nc_cnt - c_snap), 64'd0);

        // Write COMMAND
        d_snap = nd_cnt; c_snap = nc_cnt;
        wb_access(1'b1, 1'b1, 64'hA5, 1, rd);
        check_eq("s2_host_data", host_data_o, 64'hA5);
        check_eq("s2_new_cmd", 64'(nc_cnt - c_snap), 64'd1);
        check_eq("s2_new_data", 64'(nd_cnt - d_snap), 64'd0);

        // Status/data reads around a host capture
        d_snap = nd_cnt; c_snap = nc_cnt;
        wb_access(1'b0, 1'b1, '0, 1, rd);
        check_eq("s3_status_empty", rd, 64'd0);
        host_done(64'hDEADBEEF);
        wb_access(1'b0, 1'b1, '0, 1, rd);
        check_eq("s3_status_set", rd, 64'd1);
        wb_access(1'b0, 1'b0, '0, 2, rd);
        check_eq("s3_data", rd, 64'hDEADBEEF);
        check_eq("s3_wb_hold", wb_data_o, 64'hDEADBEEF);
        wb_access(1'b0, 1'b1, '0, 1, rd);
        check_eq("s3_status_clr", rd, 64'd0);
        check_eq("s3_no_pulses", 64'((nd_cnt - d_snap) + (nc_cnt - c_snap)), 64'd0);
        check_eq("s3_host_hold", host_data_o, 64'hA5);

        // Overwrite while valid: newest word wins
        host_done(64'h1111);
        host_done(64'h2222);
        wb_access(1'b0, 1'b0, '0, 1, rd);
        check_eq("ovw_data", rd, 64'h2222);

        // Long strobe then short gap gives exactly two acks
        a_snap = ack_cnt;
        wb_access(1'b1, 1'b0, 64'h77, 10, rd);
        wb_access(1'b1, 1'b0, 64'h78, 1, rd);
        check_eq("s4_two_acks", 64'(ack_cnt - a_snap), 64'd2);
        check_eq("s4_host_data", host_data_o, 64'h78);

        // Capture colliding with a DATA read
        host_done(64'h11);
        adr_i = 1'b0; we_i = 1'b0; strobe = 1'b1;
        host_data_i = 64'h55; done_i = 1'b1;
        step();
        done_i = 1'b0;
        check_eq("s6_ack", {63'd0, ack_o}, 64'd1);
        check_eq("s6_old_data", wb_data_o, 64'h11);
        strobe = 1'b0;
        step();
        wb_access(1'b0, 1'b1, '0, 1, rd);
        check_eq("s6_status", rd, 64'd1);
        wb_access(1'b0, 1'b0, '0, 1, rd);
        check_eq("s6_new_data", rd, 64'h55);

        // Reset in the middle of an ACK cycle
        we_i = 1'b1; adr_i = 1'b0; wb_data_i = 64'hCAFE; strobe = 1'b1;
        step();
        check_eq("s5_in_ack", {63'd0, ack_o}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check_eq("s5_ack_async", {63'd0, ack_o}, 64'd0);
        check_eq("s5_new_data_async", {63'd0, new_data}, 64'd0);
        check_eq("s5_host_async", host_data_o, 64'd0);
        check_eq("s5_wb_async", wb_data_o, 64'd0);
        strobe = 1'b0; we_i = 1'b0;
        step(); step();
        reset = 1'b0;
        a_snap = ack_cnt;
        repeat (5) step();
        check_eq("s5_no_ack_after", 64'(ack_cnt - a_snap), 64'd0);
        wb_access(1'b0, 1'b1, '0, 1, rd);
        check_eq("s5_status_cleared", rd, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wishbone_slave2
`default_nettype wire
